l2_fwd_sequencer: RTL and testbench
===================================

// Module: l2_fwd_sequencer
// PURPOSE
//  Single-line L2 transaction sequencer in front of the PMESH L2 line-state datapath.
//  Accepts core LOAD requests on msg1.
//  When the line is owned by another core, it issues LOAD_FWD on msg2, waits for LOAD_FWDACK on msg3,
//  pulses the datapath fill, then returns DATA_ACK to the requester on msg2.
//  One transaction in flight; other requests are back-pressured.
// PARAMETERS
//  MSG_LOAD      8'h31  msg1 type that starts a transaction
//  MSG_LOAD_FWD  8'h11  msg2 type sent to the current owner
//  MSG_FWDACK    8'h15  msg3 type that completes a forward
//  MSG_DATA_ACK  8'h24  msg2 type returned to the requester
//  TIMEOUT_CYC   255    WAIT cycles before timeout asserts (1..255)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  msg1_valid   in   1   request valid
//  msg1_ready   out  1   request accept
//  msg1_type    in   8   request type
//  msg1_source  in   6   requesting core id
//  msg1_tag     in   26  line tag
//  msg3_valid   in   1   response valid
//  msg3_ready   out  1   response accept
//  msg3_type    in   8   response type
//  msg3_source  in   6   responding core id
//  msg2_valid   out  1   outbound message valid
//  msg2_ready   in   1   outbound accept
//  msg2_type    out  8   outbound type
//  msg2_dest    out  6   outbound destination core
//  cache_state  in   2   line state from datapath (0 I, 1 S, 2 owned-remote, 3 rsvd)
//  cache_owner  in   6   owner id from datapath
//  cur_msg_state out 2   FSM state (0 IDLE, 1 FWD, 2 WAIT, 3 ACK)
//  cur_msg_source out 6  latched requester
//  cur_msg_tag  out  26  latched tag
//  fill_en      out  1   1-cycle pulse: datapath applies fwdack fill
//  stray        out  1   1-cycle pulse: msg3 or msg1 consumed and dropped
//  timeout      out  1   high while the WAIT counter is saturated
// BEHAVIOUR
//  Reset: all outputs and registers 0; FSM = IDLE.
//  Handshake: transfer when valid && ready in the same cycle.
//  Ready/valid are decoded from registered state only; no combinational input-to-output path.
//  msg2 valid is held, with type and dest stable, until msg2_ready.
//  IDLE
//   - msg1_ready = 1.
//   - On msg1 transfer with type == MSG_LOAD: latch source, tag, and owner (cache_owner).
//   - If cache_state == 2 and cache_owner != msg1_source: go to FWD. Otherwise go to ACK.
//   - On msg1 transfer with any other type: pulse stray next cycle; stay in IDLE.
//  FWD
//   - msg2_valid = 1, msg2_type = MSG_LOAD_FWD, msg2_dest = latched owner.
//   - On msg2_ready: go to WAIT and clear the counter.
//  WAIT
//   - msg3_ready = 1.
//   - msg3 with type == MSG_FWDACK and source == latched owner: pulse fill_en next cycle; go to ACK.
//   - Any other msg3: consumed, stray pulse, stay in WAIT.
//   - 8-bit counter increments each WAIT cycle and saturates at TIMEOUT_CYC.
//   - timeout is high while the counter is saturated. The FSM keeps waiting; a valid ack still completes.
//  ACK
//   - msg2_valid = 1, msg2_type = MSG_DATA_ACK, msg2_dest = latched requester.
//   - On msg2_ready: go to IDLE, clear timeout.
//  msg1_ready is 0 outside IDLE. msg3_ready is 0 outside WAIT; msg3 traffic in other states is not consumed.
//  Latency
//   - msg1 accepted in cycle N -> msg2_valid in cycle N+1.
//   - Fwdack accepted in cycle M -> fill_en and ACK-state msg2_valid in cycle M+1.
//  Reset asserted mid-transaction aborts immediately: IDLE, no msg2 emitted, latched fields cleared.
//  cache_state/cache_owner are sampled only at the IDLE accept; later changes are ignored.
// TESTING
//  1. Reset, cache_state=0, LOAD src=3 tag=0x1234 -> N+1: msg2 DATA_ACK(0x24) dest=3; ready=1 -> IDLE.
//  2. cache_state=2 owner=5, LOAD src=3 -> FWD(0x11) dest=5; msg3 0x15 src=5 -> fill_en pulse, then DATA_ACK dest=3.
//  3. In WAIT, send msg3 0x15 src=7 then 0x20 src=5 -> two stray pulses, no fill_en; then 0x15 src=5 completes.
//  4. TIMEOUT_CYC=4, hold WAIT with no msg3 -> timeout high after 4 cycles; late ack -> completes; timeout clears at IDLE.
//  5. msg2_ready=0 for 10 cycles in FWD -> msg2 fields stable, msg1_ready=0; second msg1 LOAD is not accepted.
//  6. Assert rst in WAIT -> next cycle all outputs 0, cur_msg_state=0; fwdack arriving after is not consumed.

Source files
------------

// File: rtl/l2_fwd_sequencer_if.sv
// Message bundle between the L2 forward sequencer and its surroundings.
// The master side is the core/NoC/datapath environment and the slave side is the sequencer.
// msg1: requests in, msg3: forward responses in, msg2: outbound messages.
// Also carries the datapath line state in, and the sequencer status/pulse outputs.
interface l2_fwd_sequencer_if;
   logic        msg1_valid;
   logic        msg1_ready;
   logic [7:0]  msg1_type;
   logic [5:0]  msg1_source;
   logic [25:0] msg1_tag;

   logic        msg3_valid;
   logic        msg3_ready;
   logic [7:0]  msg3_type;
   logic [5:0]  msg3_source;

   logic        msg2_valid;
   logic        msg2_ready;
   logic [7:0]  msg2_type;
   logic [5:0]  msg2_dest;

   logic [1:0]  cache_state;
   logic [5:0]  cache_owner;

   logic [1:0]  cur_msg_state;
   logic [5:0]  cur_msg_source;
   logic [25:0] cur_msg_tag;
   logic        fill_en;
   logic        stray;
   logic        timeout;

   modport master (
      output msg1_valid, msg1_type, msg1_source, msg1_tag,
      input  msg1_ready,
      output msg3_valid, msg3_type, msg3_source,
      input  msg3_ready,
      input  msg2_valid, msg2_type, msg2_dest,
      output msg2_ready,
      output cache_state, cache_owner,
      input  cur_msg_state, cur_msg_source, cur_msg_tag, fill_en, stray, timeout
   );

   modport slave (
      input  msg1_valid, msg1_type, msg1_source, msg1_tag,
      output msg1_ready,
      input  msg3_valid, msg3_type, msg3_source,
      output msg3_ready,
      output msg2_valid, msg2_type, msg2_dest,
      input  msg2_ready,
      input  cache_state, cache_owner,
      output cur_msg_state, cur_msg_source, cur_msg_tag, fill_en, stray, timeout
   );
endinterface

// File: rtl/l2_fwd_sequencer.sv
// Single-line L2 LOAD sequencer: forwards to a remote owner when needed, then returns DATA_ACK.
// Latency: msg1 accept -> msg2 valid next cycle; fwdack accept -> fill_en + DATA_ACK next cycle.
// Backpressure: one transaction in flight; msg1/msg3 ready only in IDLE/WAIT, msg2 held until ready.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries msg1/msg2/msg3 handshakes,
//        cache_state/cache_owner from the datapath, and state/latched-field/fill/stray/timeout outputs.
module l2_fwd_sequencer #(
   parameter logic [7:0] MSG_LOAD     = 8'h31,
   parameter logic [7:0] MSG_LOAD_FWD = 8'h11,
   parameter logic [7:0] MSG_FWDACK   = 8'h15,
   parameter logic [7:0] MSG_DATA_ACK = 8'h24,
   parameter logic [7:0] TIMEOUT_CYC  = 8'd255
) (
   input  logic                clk,
   input  logic                rst,
   l2_fwd_sequencer_if.slave   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_ACK  = 2'd3;

   localparam logic [1:0] CS_OWNED_REMOTE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  src_q, src_d;
   logic [25:0] tag_q, tag_d;
   logic [5:0]  owner_q, owner_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        fill_q, fill_d;
   logic        stray_q, stray_d;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      tag_d   = tag_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      fill_d  = 1'b0;
      stray_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.msg1_valid) begin
               if (bus.msg1_type == MSG_LOAD) begin
                  // Line state is sampled only here; later datapath changes do not affect this transaction.
                  src_d   = bus.msg1_source;
                  tag_d   = bus.msg1_tag;
                  owner_d = bus.cache_owner;
                  if (bus.cache_state == CS_OWNED_REMOTE && bus.cache_owner != bus.msg1_source)
                     state_d = ST_FWD;
                  else
                     state_d = ST_ACK;
               end else begin
                  stray_d = 1'b1;
               end
            end
         end
         ST_FWD: begin
            if (bus.msg2_ready) begin
               state_d = ST_WAIT;
               cnt_d   = 8'd0;
            end
         end
         ST_WAIT: begin
            if (cnt_q != TIMEOUT_CYC)
               cnt_d = cnt_q + 8'd1;
            if (bus.msg3_valid) begin
               if (bus.msg3_type == MSG_FWDACK && bus.msg3_source == owner_q) begin
                  fill_d  = 1'b1;
                  state_d = ST_ACK;
               end else begin
                  stray_d = 1'b1;
               end
            end
         end
         default: begin // ST_ACK
            // Counter survives into ACK so timeout stays visible until the requester is answered.
            if (bus.msg2_ready) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         src_q   <= 6'd0;
         tag_q   <= 26'd0;
         owner_q <= 6'd0;
         cnt_q   <= 8'd0;
         fill_q  <= 1'b0;
         stray_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         tag_q   <= tag_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         stray_q <= stray_d;
      end
   end

   // All handshake outputs decode registered state only.
   assign bus.msg1_ready     = (state_q == ST_IDLE);
   assign bus.msg3_ready     = (state_q == ST_WAIT);
   assign bus.msg2_valid     = (state_q == ST_FWD) || (state_q == ST_ACK);
   assign bus.msg2_type      = (state_q == ST_FWD) ? MSG_LOAD_FWD :
                               (state_q == ST_ACK) ? MSG_DATA_ACK : 8'd0;
   assign bus.msg2_dest      = (state_q == ST_FWD) ? owner_q :
                               (state_q == ST_ACK) ? src_q : 6'd0;
   assign bus.cur_msg_state  = state_q;
   assign bus.cur_msg_source = src_q;
   assign bus.cur_msg_tag    = tag_q;
   assign bus.fill_en        = fill_q;
   assign bus.stray          = stray_q;
   assign bus.timeout        = (cnt_q == TIMEOUT_CYC);

endmodule

// File: tb/tb_l2_fwd_sequencer.sv
// Randomized transaction-level bench for l2_fwd_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_l2_fwd_sequencer;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2_fwd_sequencer_if bus();

   l2_fwd_sequencer #(.TIMEOUT_CYC(8'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Expected phase uses the externally visible encoding: 0 IDLE, 1 FWD, 2 WAIT, 3 ACK.
   int          e_phase;
   logic [5:0]  e_src, e_own;
   logic [25:0] e_tag;
   logic        e_fill, e_stray, e_tmo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string ph);
      chk({ph, ".state"}, 32'(bus.cur_msg_state), 32'(e_phase));
      chk({ph, ".m2v"},   32'(bus.msg2_valid), 32'(e_phase == 1 || e_phase == 3));
      if (e_phase == 1) begin
         chk({ph, ".m2type"}, 32'(bus.msg2_type), 32'h11);
         chk({ph, ".m2dest"}, 32'(bus.msg2_dest), 32'(e_own));
      end else if (e_phase == 3) begin
         chk({ph, ".m2type"}, 32'(bus.msg2_type), 32'h24);
         chk({ph, ".m2dest"}, 32'(bus.msg2_dest), 32'(e_src));
      end
      chk({ph, ".m1rdy"}, 32'(bus.msg1_ready), 32'(e_phase == 0));
      chk({ph, ".m3rdy"}, 32'(bus.msg3_ready), 32'(e_phase == 2));
      chk({ph, ".src"},   32'(bus.cur_msg_source), 32'(e_src));
      chk({ph, ".tag"},   32'(bus.cur_msg_tag), 32'(e_tag));
      chk({ph, ".fill"},  32'(bus.fill_en), 32'(e_fill));
      chk({ph, ".stray"}, 32'(bus.stray), 32'(e_stray));
      chk({ph, ".tmo"},   32'(bus.timeout), 32'(e_tmo));
   endtask

   task automatic step(input string ph);
      @(negedge clk);
      check_outs(ph);
   endtask

   task automatic quiet();
      bus.msg1_valid  = 1'b0;
      bus.msg1_type   = 8'h00;
      bus.msg1_source = 6'd0;
      bus.msg1_tag    = 26'd0;
      bus.msg3_valid  = 1'b0;
      bus.msg3_type   = 8'h00;
      bus.msg3_source = 6'd0;
      bus.msg2_ready  = 1'($urandom);
      bus.cache_state = 2'(($urandom));
      bus.cache_owner = 6'($urandom);
   endtask

   // Traffic that must be ignored outside the state that accepts it.
   task automatic noise();
      bus.msg1_valid  = 1'($urandom);
      bus.msg1_type   = ($urandom_range(0, 1) == 0) ? 8'h31 : 8'($urandom);
      bus.msg1_source = 6'($urandom);
      bus.msg1_tag    = 26'($urandom);
      bus.msg3_valid  = 1'($urandom);
      bus.msg3_type   = ($urandom_range(0, 1) == 0) ? 8'h15 : 8'($urandom);
      bus.msg3_source = ($urandom_range(0, 1) == 0) ? e_own : 6'($urandom);
      bus.cache_state = 2'($urandom);
      bus.cache_owner = 6'($urandom);
   endtask

   // One complete LOAD transaction starting from a checked IDLE cycle.
   task automatic run_txn(input logic [5:0] src, input logic [25:0] tag, input logic [1:0] cs,
                          input logic [5:0] own, input int fwd_hold, input int wait_len,
                          input int ack_hold, input bit junk);
      bit fwd;
      int wn;
      fwd = (cs == 2'd2) && (own != src);
      wn  = 0;

      if (junk) begin
         quiet();
         bus.msg1_valid  = 1'b1;
         bus.msg1_type   = 8'($urandom_range(0, 255));
         if (bus.msg1_type == 8'h31) bus.msg1_type = 8'h30;
         bus.msg1_source = 6'($urandom);
         e_stray = 1'b1; e_fill = 1'b0;
         step("idle_stray");
      end

      quiet();
      bus.msg1_valid  = 1'b1;
      bus.msg1_type   = 8'h31;
      bus.msg1_source = src;
      bus.msg1_tag    = tag;
      bus.cache_state = cs;
      bus.cache_owner = own;
      if (junk) begin
         bus.msg3_valid = 1'b1; bus.msg3_type = 8'h15; bus.msg3_source = own;
      end
      e_phase = fwd ? 1 : 3;
      e_src = src; e_tag = tag; e_own = own;
      e_stray = 1'b0; e_fill = 1'b0; e_tmo = 1'b0;
      step("accept");

      if (fwd) begin
         for (int i = 0; i < fwd_hold; i++) begin
            noise();
            bus.msg2_ready = 1'b0;
            step("fwd_hold");
         end
         noise();
         bus.msg2_ready = 1'b1;
         e_phase = 2;
         step("fwd_go");
         for (int i = 0; i < wait_len; i++) begin
            quiet();
            e_stray = 1'b0;
            if (junk && $urandom_range(0, 1) == 1) begin
               bus.msg3_valid  = 1'b1;
               bus.msg3_type   = ($urandom_range(0, 1) == 0) ? 8'h15 : 8'($urandom);
               bus.msg3_source = 6'($urandom);
               if (bus.msg3_type == 8'h15 && bus.msg3_source == own)
                  bus.msg3_source = own ^ 6'd1;
               e_stray = 1'b1;
            end
            wn++;
            e_tmo = (wn >= T);
            step("wait");
         end
         quiet();
         bus.msg3_valid  = 1'b1;
         bus.msg3_type   = 8'h15;
         bus.msg3_source = own;
         wn++;
         e_tmo = (wn >= T);
         e_phase = 3; e_fill = 1'b1; e_stray = 1'b0;
         step("fwdack");
      end

      for (int i = 0; i < ack_hold; i++) begin
         noise();
         bus.msg2_ready = 1'b0;
         e_fill = 1'b0; e_stray = 1'b0;
         step("ack_hold");
      end
      noise();
      bus.msg1_valid = 1'b0;
      bus.msg2_ready = 1'b1;
      e_phase = 0; e_fill = 1'b0; e_stray = 1'b0; e_tmo = 1'b0;
      step("ack_go");
   endtask

   initial begin
      quiet();
      rst = 1'b1;
      e_phase = 0; e_src = '0; e_tag = '0; e_own = '0;
      e_fill = 1'b0; e_stray = 1'b0; e_tmo = 1'b0;
      step("reset");
      chk("reset.m2type", 32'(bus.msg2_type), 32'h0);
      chk("reset.m2dest", 32'(bus.msg2_dest), 32'h0);
      rst = 1'b0;
      step("post_reset");

      // Local owner: direct DATA_ACK.
      run_txn(6'd3, 26'h1234, 2'd0, 6'd0, 0, 0, 0, 1'b0);
      // Remote owner: forward then fill.
      run_txn(6'd3, 26'h0abc, 2'd2, 6'd5, 0, 1, 1, 1'b0);
      // Strays during WAIT.
      run_txn(6'd3, 26'h5555, 2'd2, 6'd5, 1, 6, 0, 1'b1);
      // Long WAIT reaching timeout, then late ack.
      run_txn(6'd9, 26'h0777, 2'd2, 6'd1, 0, 9, 2, 1'b0);
      // Long msg2 backpressure in FWD.
      run_txn(6'd2, 26'h3ffffff, 2'd2, 6'd7, 10, 2, 3, 1'b1);
      // Owned-remote but owner is the requester: no forward.
      run_txn(6'd4, 26'h0042, 2'd2, 6'd4, 0, 0, 1, 1'b0);

      for (int n = 0; n < 40; n++)
         run_txn(6'($urandom), 26'($urandom), 2'($urandom), 6'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(0, 3),
                 1'($urandom));

      // Reset in WAIT aborts; a fwdack afterwards is not consumed.
      quiet();
      bus.msg1_valid = 1'b1; bus.msg1_type = 8'h31; bus.msg1_source = 6'd3;
      bus.msg1_tag = 26'h99; bus.cache_state = 2'd2; bus.cache_owner = 6'd5;
      e_phase = 1; e_src = 6'd3; e_tag = 26'h99; e_own = 6'd5;
      step("rst_acc");
      quiet();
      bus.msg2_ready = 1'b1;
      e_phase = 2;
      step("rst_fwd");
      quiet();
      e_tmo = 1'b0;
      step("rst_wait");
      quiet();
      rst = 1'b1;
      bus.msg3_valid = 1'b1; bus.msg3_type = 8'h15; bus.msg3_source = 6'd5;
      e_phase = 0; e_src = '0; e_tag = '0; e_own = '0;
      e_fill = 1'b0; e_stray = 1'b0; e_tmo = 1'b0;
      step("rst_mid");
      chk("rst_mid.m2type", 32'(bus.msg2_type), 32'h0);
      chk("rst_mid.m2dest", 32'(bus.msg2_dest), 32'h0);
      rst = 1'b0;
      step("rst_after1");
      step("rst_after2");
      bus.msg3_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
